// File: rtl/page_tbl_rd_wr_ctrl_pkg.sv
// page_tbl_pkg: shared defaults, controller states and response FIFO depth
package page_tbl_pkg;
    localparam int ADDR_BITS_DEF = 5;
    localparam int DATA_BITS_DEF = 16;
    localparam int RSP_FIFO_DEPTH = 3;
    typedef enum logic {CLR, RUN} state_e;
endpackage

// File: rtl/page_tbl_rd_wr_ctrl_if.sv
// page_tbl_rd_wr_ctrl_if: write and lookup channels between packet-buffer logic and the controller
interface page_tbl_rd_wr_ctrl_if
    import page_tbl_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
);
    logic                 init_done;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 rd_req_valid;
    logic                 rd_req_ready;
    logic [ADDR_BITS-1:0] rd_req_addr;
    logic                 rd_rsp_valid;
    logic                 rd_rsp_ready;
    logic [DATA_BITS-1:0] rd_rsp_data;
    modport master (
        input  init_done, wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_rsp_ready
    );
    modport slave (
        output init_done, wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_rsp_ready
    );
endinterface

// File: rtl/page_tbl_rd_wr_ctrl_mem.sv
// page_tbl_16w_32d: simple dual-port page table storage, write port A, registered read port B
module page_tbl_16w_32d #(
    parameter int ADDR_BITS = 5,
    parameter int DATA_BITS = 16
) (
    input  logic                 clka_i,
    input  logic                 ena_i,
    input  logic                 wea_i,
    input  logic [ADDR_BITS-1:0] addra_i,
    input  logic [DATA_BITS-1:0] dina_i,
    input  logic                 clkb_i,
    input  logic                 enb_i,
    input  logic [ADDR_BITS-1:0] addrb_i,
    output logic [DATA_BITS-1:0] doutb_o
);
    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

    // Port A write
    always_ff @(posedge clka_i) begin
        if (ena_i && wea_i) mem_q[addra_i] <= dina_i;
    end

    // Port B read, data valid one cycle after enable
    always_ff @(posedge clkb_i) begin
        if (enb_i) doutb_o <= mem_q[addrb_i];
    end
endmodule

// File: rtl/page_tbl_rd_wr_ctrl.sv
// page_tbl_rd_wr_ctrl: page table clear sweep, write channel and lookup pipeline with response skid FIFO
module page_tbl_rd_wr_ctrl
    import page_tbl_pkg::*;
#(
    parameter int                   ADDR_BITS = ADDR_BITS_DEF,
    parameter int                   DATA_BITS = DATA_BITS_DEF,
    parameter logic [DATA_BITS-1:0] CLR_VALUE = '0
) (
    input logic                 clk,
    input logic                 rst,
    page_tbl_rd_wr_ctrl_if.slave bus
);
    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                 s1_valid_q, s1_valid_d, s1_byp_q, s1_byp_d;
    logic [DATA_BITS-1:0] s1_data_q, s1_data_d;
    logic [DATA_BITS-1:0] fifo_q [RSP_FIFO_DEPTH];
    logic [DATA_BITS-1:0] fifo_d [RSP_FIFO_DEPTH];
    logic [1:0]           cnt_q, cnt_d;
    logic                 run, rd_ready, wr_fire, rd_fire, push, pop, ena, enb;
    logic [ADDR_BITS-1:0] addra;
    logic [DATA_BITS-1:0] dina, doutb, push_data;

    page_tbl_16w_32d #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_mem (
        .clka_i (clk),
        .ena_i  (ena),
        .wea_i  (ena),
        .addra_i(addra),
        .dina_i (dina),
        .clkb_i (clk),
        .enb_i  (enb),
        .addrb_i(bus.rd_req_addr),
        .doutb_o(doutb)
    );

    // Sweep/run control, channel handshakes, port drive and S1 capture
    always_comb begin
        run              = state_q == RUN;
        rd_ready         = run && ({1'b0, cnt_q} + {2'b0, s1_valid_q}) < 3'(RSP_FIFO_DEPTH);
        bus.init_done    = run;
        bus.wr_ready     = run;
        bus.rd_req_ready = rd_ready;
        wr_fire          = bus.wr_valid && run;
        rd_fire          = bus.rd_req_valid && rd_ready;
        ena              = !run || wr_fire;
        addra            = run ? bus.wr_addr : ptr_q;
        dina             = run ? bus.wr_data : CLR_VALUE;
        enb              = rd_fire;
        ptr_d            = run ? ptr_q : ptr_q + 1'b1;
        state_d          = (run || &ptr_q) ? RUN : CLR;
        s1_valid_d       = rd_fire;
        s1_byp_d         = rd_fire && wr_fire && bus.wr_addr == bus.rd_req_addr;
        s1_data_d        = bus.wr_data;
    end

    // Skid FIFO: head in slot 0, pop shifts down, push lands behind the survivors
    always_comb begin
        bus.rd_rsp_valid = cnt_q != 2'd0;
        bus.rd_rsp_data  = fifo_q[0];
        pop              = bus.rd_rsp_valid && bus.rd_rsp_ready;
        push             = s1_valid_q;
        push_data        = s1_byp_q ? s1_data_q : doutb;
        fifo_d           = fifo_q;
        for (int i = 0; i < RSP_FIFO_DEPTH - 1; i++) fifo_d[i] = pop ? fifo_q[i+1] : fifo_q[i];
        if (push) fifo_d[cnt_q - {1'b0, pop}] = push_data;
        cnt_d            = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // State, S1 and FIFO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLR;
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_data_q  <= '0;
            cnt_q      <= '0;
            fifo_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_byp_q   <= s1_byp_d;
            s1_data_q  <= s1_data_d;
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
        end
    end

    // Credits guarantee a free slot for every S1 push
    always_ff @(posedge clk) begin
        if (!rst && push) assert (cnt_q != 2'(RSP_FIFO_DEPTH));
    end
endmodule

// File: tb/tb_page_tbl_rd_wr_ctrl.sv
// tb_page_tbl_rd_wr_ctrl: directed plan plus random traffic against a transaction-level page table model
module tb_page_tbl_rd_wr_ctrl;
    typedef struct { logic [15:0] d; int e; } rec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errs = 0, checks = 0;
    rec_t        exp_q[$], obs_q[$], r;
    logic [15:0] mem_m [32];
    int          since = 0, e = 0;
    bit          mon_en = 0, hold = 0, done_exp, rdy, rv, f;
    logic [15:0] hold_data;
    int          bp_a [5] = '{1, 2, 3, 4, 6};
    int          acc, n;

    page_tbl_rd_wr_ctrl_if bus ();
    page_tbl_rd_wr_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        int k = 0;
        bus.wr_valid = 1; bus.wr_addr = a; bus.wr_data = d;
        while (!bus.wr_ready && k < 50) begin tick(); k++; end
        chk("wr_accept_wait", k < 50, 1);
        tick();
        bus.wr_valid = 0;
    endtask

    task automatic rd(input logic [4:0] a);
        int k = 0;
        bus.rd_req_valid = 1; bus.rd_req_addr = a;
        while (!bus.rd_req_ready && k < 50) begin tick(); k++; end
        chk("rd_accept_wait", k < 50, 1);
        tick();
        bus.rd_req_valid = 0;
    endtask

    task automatic wait_init();
        int k = 0;
        while (!bus.init_done && k < 100) begin tick(); k++; end
        chk("clr_cycles", k, 32);
    endtask

    // Reference model: outstanding lookups in a queue, table in an array; evaluated mid-cycle
    always @(negedge clk) begin
        if (mon_en) begin
            done_exp = since >= 32;
            rdy = done_exp && exp_q.size() < 3;
            rv = exp_q.size() > 0 && exp_q[0].e < e - 1;
            chk("init_done", bus.init_done, done_exp);
            chk("wr_ready", bus.wr_ready, done_exp);
            chk("rd_req_ready", bus.rd_req_ready, rdy);
            chk("rd_rsp_valid", bus.rd_rsp_valid, rv);
            if (hold) chk("rsp_hold", bus.rd_rsp_data, hold_data);
            if (rst) begin
                exp_q.delete();
                since = 0;
                hold = 0;
                foreach (mem_m[i]) mem_m[i] = 16'h0;
            end else begin
                if (rv && bus.rd_rsp_ready) begin
                    r = exp_q.pop_front();
                    chk("rsp_data", bus.rd_rsp_data, r.d);
                    obs_q.push_back('{bus.rd_rsp_data, e});
                end
                if (rdy && bus.rd_req_valid)
                    exp_q.push_back('{(done_exp && bus.wr_valid && bus.wr_addr == bus.rd_req_addr)
                                      ? bus.wr_data : mem_m[bus.rd_req_addr], e});
                if (done_exp && bus.wr_valid) mem_m[bus.wr_addr] = bus.wr_data;
                if (since < 32) since++;
                hold = bus.rd_rsp_valid && !bus.rd_rsp_ready;
                hold_data = bus.rd_rsp_data;
            end
        end
        e++;
    end

    initial begin
        bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_req_valid = 0; bus.rd_req_addr = 0; bus.rd_rsp_ready = 0;
        tick();
        tick();
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_rsp_valid", bus.rd_rsp_valid, 0);
        chk("rst_rsp_data", bus.rd_rsp_data, 0);
        mon_en = 1;
        rst = 0;
        wait_init();
        bus.rd_rsp_ready = 1;
        obs_q.delete();
        rd(0); rd(17); rd(31);
        repeat (3) tick();
        chk("clr_lookups", obs_q.size(), 3);
        foreach (obs_q[i]) chk("clr_value", obs_q[i].d, 16'h0000);
        wr(5, 16'hBEEF);
        rd(5);
        chk("wr_rd_early", bus.rd_rsp_valid, 0);
        tick();
        chk("wr_rd_valid", bus.rd_rsp_valid, 1);
        chk("wr_rd_data", bus.rd_rsp_data, 16'hBEEF);
        bus.wr_valid = 1; bus.wr_addr = 9; bus.wr_data = 16'h1234;
        bus.rd_req_valid = 1; bus.rd_req_addr = 9;
        chk("coll_ready", bus.rd_req_ready, 1);
        tick();
        bus.wr_valid = 0; bus.rd_req_valid = 0;
        tick();
        chk("coll_valid", bus.rd_rsp_valid, 1);
        chk("coll_data", bus.rd_rsp_data, 16'h1234);
        rd(9);
        tick();
        chk("coll_again", bus.rd_rsp_data, 16'h1234);
        for (int i = 0; i < 32; i++) wr(5'(i), 16'(i * 257));
        repeat (3) tick();
        obs_q.delete();
        for (int i = 0; i < 32; i++) begin
            bus.rd_req_valid = 1; bus.rd_req_addr = 5'(i);
            chk("tput_ready", bus.rd_req_ready, 1);
            tick();
        end
        bus.rd_req_valid = 0;
        repeat (4) tick();
        chk("tput_count", obs_q.size(), 32);
        foreach (obs_q[i]) begin
            chk("tput_data", obs_q[i].d, 32'(i * 257));
            chk("tput_cycle", obs_q[i].e - obs_q[0].e, i);
        end
        obs_q.delete();
        bus.rd_rsp_ready = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.rd_req_valid = 1; bus.rd_req_addr = 5'(bp_a[acc]);
            f = bus.rd_req_ready;
            tick();
            if (f) acc++;
        end
        chk("bp_accepted", acc, 3);
        chk("bp_ready_low", bus.rd_req_ready, 0);
        chk("bp_head", bus.rd_rsp_data, 16'h0101);
        repeat (2) tick();
        chk("bp_head_stable", bus.rd_rsp_data, 16'h0101);
        bus.rd_rsp_ready = 1;
        n = 0;
        while (acc < 5 && n < 20) begin
            bus.rd_req_addr = 5'(bp_a[acc]);
            f = bus.rd_req_ready;
            tick();
            if (f) acc++;
            n++;
        end
        bus.rd_req_valid = 0;
        chk("bp_all_accepted", acc, 5);
        repeat (6) tick();
        chk("bp_count", obs_q.size(), 5);
        foreach (obs_q[i]) chk("bp_order", obs_q[i].d, 32'(bp_a[i] * 257));
        bus.rd_rsp_ready = 0;
        rd(5); rd(5); rd(5);
        tick();
        chk("mid_queued", bus.rd_rsp_valid, 1);
        obs_q.delete();
        rst = 1;
        tick();
        chk("mid_rst_valid", bus.rd_rsp_valid, 0);
        tick();
        rst = 0;
        bus.rd_rsp_ready = 1;
        wait_init();
        chk("mid_dropped", obs_q.size(), 0);
        rd(5);
        repeat (3) tick();
        chk("mid_lookup_count", obs_q.size(), 1);
        if (obs_q.size() > 0) chk("mid_lookup_data", obs_q[0].d, 16'h0000);
        for (int c = 0; c < 1500; c++) begin
            bus.wr_valid     = 1'($urandom_range(0, 1));
            bus.wr_addr      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.wr_data      = 16'($urandom);
            bus.rd_req_valid = 1'($urandom_range(0, 1));
            bus.rd_req_addr  = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            bus.rd_rsp_ready = $urandom_range(0, 3) != 0;
            rst              = c >= 700 && c < 702;
            tick();
        end
        bus.wr_valid = 0; bus.rd_req_valid = 0; bus.rd_rsp_ready = 1; rst = 0;
        repeat (8) tick();
        chk("drain_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
